// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the skid-buffered pipeline stage
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } pipe_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // IF->ID payload; instr sits in the top bits of the 96-bit bus
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // Number of held entries implied by a state
  function automatic logic [1:0] occ_of(pipe_state_t s);
    case (s)
      FULL1:   return 2'd1;
      FULL2:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - async-reset payload register with load and clear-to-reset-value
module pipe_data_reg #(
  parameter int                WIDTH   = 96,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a kill never lets a stale payload slip in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (clear) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage with 2-entry skid buffer and flush
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH           = 96,
  parameter logic [WIDTH-1:0] BUBBLE          = '0,
  parameter bit               BUBBLE_ON_EMPTY = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state, state_n;
  logic             accept, send;
  logic             main_load, main_clear, main_from_skid;
  logic             skid_load, skid_clear;
  logic             skid_valid_n;
  logic [WIDTH-1:0] main_d, skid_q;

  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;
  assign out_valid = (state != EMPTY);

  // Next-state and register-enable decode; flush overrides every handshake
  always_comb begin
    state_n        = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_n    = EMPTY;
      main_clear = BUBBLE_ON_EMPTY;
      skid_clear = BUBBLE_ON_EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_n   = FULL1;
          end
        end
        FULL1: begin
          if (accept && send) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_n   = FULL2;
          end else if (send) begin
            main_clear = BUBBLE_ON_EMPTY;
            state_n    = EMPTY;
          end
        end
        FULL2: begin
          if (send) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = BUBBLE_ON_EMPTY;
            state_n        = FULL1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  assign skid_valid_n = (state_n == FULL2);
  assign main_d       = main_from_skid ? skid_q : in_data;

  // State, registered ready and registered occupancy all track the same next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state     <= state_n;
      in_ready  <= ~skid_valid_n;
      occupancy <= occ_of(state_n);
    end
  end

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (BUBBLE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (BUBBLE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
